mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one memory port between the CPU's instruction-fetch (IFU) and load/store (LSU) request interfaces.
- Buffers one request per requester and grants the port with fixed LSU-over-IFU priority.
- Tracks each transaction to completion and returns registered responses to the owning requester.
- Bounds every transaction with a timeout counter; an expired transaction gets an error response so the CPU state machine never hangs.

Parameters:
- TIMEOUT, 255, BUSY cycles without io_mem_respValid before an error response is returned; 0 disables the timeout.
- ERR_DATA, 32'hDEADBEEF, rdata value returned on a timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- io_ifu_reqValid  in  1  one-cycle request pulse
- io_ifu_addr  in  32  fetch address, sampled with reqValid
- io_ifu_respValid  out  1  one-cycle response pulse
- io_ifu_rdata  out  32  fetched word, valid with respValid
- io_ifu_err  out  1  timeout flag, valid with respValid
- io_lsu_reqValid  in  1  one-cycle request pulse
- io_lsu_addr  in  32  access address
- io_lsu_size  in  2  0=byte, 1=half, 2=word
- io_lsu_wen  in  1  1=store
- io_lsu_wdata  in  32  store data
- io_lsu_wmask  in  4  store byte mask
- io_lsu_respValid  out  1  one-cycle response pulse
- io_lsu_rdata  out  32  load data
- io_lsu_err  out  1  timeout flag
- io_mem_reqValid  out  1  one-cycle request pulse to memory
- io_mem_addr  out  32  held stable while BUSY
- io_mem_size  out  2  held stable while BUSY
- io_mem_wen  out  1  held stable while BUSY
- io_mem_wdata  out  32  held stable while BUSY
- io_mem_wmask  out  4  held stable while BUSY
- io_mem_respValid  in  1  memory completion pulse
- io_mem_rdata  in  32  memory read data
- busy  out  1  high in any BUSY state
- grant  out  2  00=none, 01=IFU, 10=LSU

Behaviour:
- Reset: all outputs 0, state IDLE, both pending buffers empty, counter 0.
- Request buffering:
  - A reqValid pulse loads that requester's buffer (fields sampled in the same cycle) and sets its pending bit.
  - A pulse while that requester already has a request pending or in flight is ignored.
- States:
  - IDLE: if LSU pending -> BUSY_LSU; else if IFU pending -> BUSY_IFU. The granted pending bit clears on the transition.
  - BUSY_x:
    - io_mem_reqValid is high in the first BUSY cycle only.
    - io_mem_* fields are driven from the granted buffer for the whole BUSY period.
    - IFU grant forces wen=0, wmask=0, size=2'b10.
- Completion:
  - io_mem_respValid in BUSY cycle R -> next cycle: io_x_respValid=1, io_x_rdata=io_mem_rdata, io_x_err=0, state IDLE.
- Latency:
  - Pulse at cycle T (arbiter IDLE, no competitor) -> io_mem_reqValid at T+1.
  - Back-to-back: the next grant's io_mem_reqValid comes at R+2 (IDLE occupies R+1).
- Timeout (TIMEOUT>0):
  - Counter clears on BUSY entry and increments each BUSY cycle without io_mem_respValid.
  - After TIMEOUT such cycles: next cycle io_x_respValid=1, rdata=ERR_DATA, err=1, state IDLE.
  - io_mem_respValid in the final counted cycle wins: normal response, err=0.
- Stray io_mem_respValid in IDLE is ignored; a late memory response after a timeout is ignored.
- Response outputs are single-cycle pulses; rdata and err hold their last values otherwise.
- A requester pulse arriving while the other requester is BUSY is buffered and granted after return to IDLE.
- The counter saturates and never wraps.
- Reset mid-transaction: immediate return to IDLE; buffers dropped; no response issued.

Test Plan:
- IFU pulse at cycle 0, addr 0x8000_0000; memory responds cycle 3 with rdata 0x0010_0093 -> io_mem_reqValid cycle 1 with addr 0x8000_0000, wen=0, size=2; io_ifu_respValid cycle 4 with rdata 0x0010_0093, err=0.
- IFU and LSU pulse same cycle 0 (LSU store to 0x100, wdata 0xAB, wmask 4'b0001); memory responds cycle 2 -> LSU granted: io_mem_reqValid cycle 1 with addr 0x100, wen=1; io_lsu_respValid cycle 3; IFU io_mem_reqValid cycle 4.
- TIMEOUT=4, IFU pulse cycle 0, memory silent -> io_ifu_respValid cycle 6 (BUSY cycles 1–4 counted, IDLE return at cycle 5 edge... response at 5+1 per completion rule), rdata 0xDEADBEEF, err=1; io_mem_respValid pulse at cycle 8 is ignored.
- TIMEOUT=4, io_mem_respValid on the 4th counted BUSY cycle -> normal response next cycle, err=0.
- Reset asserted mid-BUSY, then released; memory responds afterwards -> no respValid on either port; busy=0; grant=0.
- Second IFU pulse while the first is in flight -> ignored; exactly one io_mem_reqValid and one io_ifu_respValid observed.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory-port arbiter: buffers one IFU and one LSU request, grants the port LSU-first,
// tracks each transaction to completion or timeout and returns a registered response.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_ifu_reqValid,
    input  logic [31:0] io_ifu_addr,
    output logic        io_ifu_respValid,
    output logic [31:0] io_ifu_rdata,
    output logic        io_ifu_err,
    input  logic        io_lsu_reqValid,
    input  logic [31:0] io_lsu_addr,
    input  logic [1:0]  io_lsu_size,
    input  logic        io_lsu_wen,
    input  logic [31:0] io_lsu_wdata,
    input  logic [3:0]  io_lsu_wmask,
    output logic        io_lsu_respValid,
    output logic [31:0] io_lsu_rdata,
    output logic        io_lsu_err,
    output logic        io_mem_reqValid,
    output logic [31:0] io_mem_addr,
    output logic [1:0]  io_mem_size,
    output logic        io_mem_wen,
    output logic [31:0] io_mem_wdata,
    output logic [3:0]  io_mem_wmask,
    input  logic        io_mem_respValid,
    input  logic [31:0] io_mem_rdata,
    output logic        busy,
    output logic [1:0]  grant
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IFU, BUSY_LSU} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    state_t      state_q, state_d;
    logic        ifu_pend_q, ifu_pend_d;
    logic        lsu_pend_q, lsu_pend_d;
    logic [31:0] ifu_addr_q, ifu_addr_d;
    req_t        lsu_buf_q, lsu_buf_d;
    req_t        mem_q, mem_d;
    logic        mem_valid_q, mem_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        ifu_resp_q, ifu_resp_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic        ifu_err_q, ifu_err_d;
    logic        lsu_resp_q, lsu_resp_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        lsu_err_q, lsu_err_d;
    logic        finish;
    logic [31:0] fin_rdata;
    logic        fin_err;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        ifu_pend_d  = ifu_pend_q;
        lsu_pend_d  = lsu_pend_q;
        ifu_addr_d  = ifu_addr_q;
        lsu_buf_d   = lsu_buf_q;
        mem_d       = mem_q;
        mem_valid_d = 1'b0;
        cnt_d       = cnt_q;
        ifu_resp_d  = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        ifu_err_d   = ifu_err_q;
        lsu_resp_d  = 1'b0;
        lsu_rdata_d = lsu_rdata_q;
        lsu_err_d   = lsu_err_q;
        finish      = 1'b0;
        fin_rdata   = io_mem_rdata;
        fin_err     = 1'b0;

        // A requester holds at most one outstanding transaction; extra pulses are dropped.
        if (io_ifu_reqValid && !ifu_pend_q && state_q != BUSY_IFU) begin
            ifu_pend_d = 1'b1;
            ifu_addr_d = io_ifu_addr;
        end
        if (io_lsu_reqValid && !lsu_pend_q && state_q != BUSY_LSU) begin
            lsu_pend_d = 1'b1;
            lsu_buf_d  = '{addr: io_lsu_addr, size: io_lsu_size, wen: io_lsu_wen,
                           wdata: io_lsu_wdata, wmask: io_lsu_wmask};
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Arbitrate on the _d view so a fresh pulse is granted without an extra cycle.
                if (lsu_pend_d) begin
                    state_d     = BUSY_LSU;
                    lsu_pend_d  = 1'b0;
                    mem_valid_d = 1'b1;
                    mem_d       = lsu_buf_d;
                end else if (ifu_pend_d) begin
                    state_d     = BUSY_IFU;
                    ifu_pend_d  = 1'b0;
                    mem_valid_d = 1'b1;
                    mem_d       = '{addr: ifu_addr_d, size: 2'b10, wen: 1'b0,
                                    wdata: '0, wmask: 4'b0000};
                end
            end
            default: begin
                if (io_mem_respValid) begin
                    finish = 1'b1;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
                    finish    = 1'b1;
                    fin_rdata = ERR_DATA;
                    fin_err   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        if (finish) begin
            state_d = IDLE;
            if (state_q == BUSY_IFU) begin
                ifu_resp_d  = 1'b1;
                ifu_rdata_d = fin_rdata;
                ifu_err_d   = fin_err;
            end else begin
                lsu_resp_d  = 1'b1;
                lsu_rdata_d = fin_rdata;
                lsu_err_d   = fin_err;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; buffers are reset too since they are only a few flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ifu_pend_q  <= 1'b0;
            lsu_pend_q  <= 1'b0;
            ifu_addr_q  <= '0;
            lsu_buf_q   <= '0;
            mem_q       <= '0;
            mem_valid_q <= 1'b0;
            cnt_q       <= '0;
            ifu_resp_q  <= 1'b0;
            ifu_rdata_q <= '0;
            ifu_err_q   <= 1'b0;
            lsu_resp_q  <= 1'b0;
            lsu_rdata_q <= '0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ifu_pend_q  <= ifu_pend_d;
            lsu_pend_q  <= lsu_pend_d;
            ifu_addr_q  <= ifu_addr_d;
            lsu_buf_q   <= lsu_buf_d;
            mem_q       <= mem_d;
            mem_valid_q <= mem_valid_d;
            cnt_q       <= cnt_d;
            ifu_resp_q  <= ifu_resp_d;
            ifu_rdata_q <= ifu_rdata_d;
            ifu_err_q   <= ifu_err_d;
            lsu_resp_q  <= lsu_resp_d;
            lsu_rdata_q <= lsu_rdata_d;
            lsu_err_q   <= lsu_err_d;
        end
    end

    assign io_mem_reqValid  = mem_valid_q;
    assign io_mem_addr      = mem_q.addr;
    assign io_mem_size      = mem_q.size;
    assign io_mem_wen       = mem_q.wen;
    assign io_mem_wdata     = mem_q.wdata;
    assign io_mem_wmask     = mem_q.wmask;
    assign io_ifu_respValid = ifu_resp_q;
    assign io_ifu_rdata     = ifu_rdata_q;
    assign io_ifu_err       = ifu_err_q;
    assign io_lsu_respValid = lsu_resp_q;
    assign io_lsu_rdata     = lsu_rdata_q;
    assign io_lsu_err       = lsu_err_q;
    assign busy             = (state_q != IDLE);
    assign grant            = (state_q == BUSY_IFU) ? 2'b01 :
                              (state_q == BUSY_LSU) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-accurate bench for mem_arbiter (TIMEOUT=4): expected memory requests and
// requester responses are queued with their due cycle and checked by two monitors.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_ifu_reqValid = 1'b0;
    logic [31:0] io_ifu_addr = '0;
    logic        io_ifu_respValid;
    logic [31:0] io_ifu_rdata;
    logic        io_ifu_err;
    logic        io_lsu_reqValid = 1'b0;
    logic [31:0] io_lsu_addr = '0;
    logic [1:0]  io_lsu_size = '0;
    logic        io_lsu_wen = 1'b0;
    logic [31:0] io_lsu_wdata = '0;
    logic [3:0]  io_lsu_wmask = '0;
    logic        io_lsu_respValid;
    logic [31:0] io_lsu_rdata;
    logic        io_lsu_err;
    logic        io_mem_reqValid;
    logic [31:0] io_mem_addr;
    logic [1:0]  io_mem_size;
    logic        io_mem_wen;
    logic [31:0] io_mem_wdata;
    logic [3:0]  io_mem_wmask;
    logic        io_mem_respValid = 1'b0;
    logic [31:0] io_mem_rdata = '0;
    logic        busy;
    logic [1:0]  grant;

    mem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clock(clock), .reset(reset),
        .io_ifu_reqValid(io_ifu_reqValid), .io_ifu_addr(io_ifu_addr),
        .io_ifu_respValid(io_ifu_respValid), .io_ifu_rdata(io_ifu_rdata), .io_ifu_err(io_ifu_err),
        .io_lsu_reqValid(io_lsu_reqValid), .io_lsu_addr(io_lsu_addr), .io_lsu_size(io_lsu_size),
        .io_lsu_wen(io_lsu_wen), .io_lsu_wdata(io_lsu_wdata), .io_lsu_wmask(io_lsu_wmask),
        .io_lsu_respValid(io_lsu_respValid), .io_lsu_rdata(io_lsu_rdata), .io_lsu_err(io_lsu_err),
        .io_mem_reqValid(io_mem_reqValid), .io_mem_addr(io_mem_addr), .io_mem_size(io_mem_size),
        .io_mem_wen(io_mem_wen), .io_mem_wdata(io_mem_wdata), .io_mem_wmask(io_mem_wmask),
        .io_mem_respValid(io_mem_respValid), .io_mem_rdata(io_mem_rdata),
        .busy(busy), .grant(grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          port;   // 0 = IFU, 1 = LSU
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          cyc;
    } mreq_t;

    resp_t resp_sb[$];
    mreq_t mreq_sb[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic mem_respond(input logic [31:0] d);
        io_mem_respValid = 1'b1;
        io_mem_rdata     = d;
        tick();
        io_mem_respValid = 1'b0;
    endtask

    task automatic exp_ifu_req(input logic [31:0] a, input int c);
        mreq_sb.push_back('{addr: a, size: 2'b10, wen: 1'b0, wdata: '0, wmask: 4'b0000, cyc: c});
    endtask

    task automatic exp_resp(input int p, input logic [31:0] d, input logic e, input int c);
        resp_sb.push_back('{port: p, rdata: d, err: e, cyc: c});
    endtask

    // Response monitor: every response pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && (io_ifu_respValid || io_lsu_respValid)) begin
            int    got_port;
            resp_t e;
            got_port = io_lsu_respValid ? 1 : 0;
            check("resp_single", {io_ifu_respValid, io_lsu_respValid} == 2'b11, 1'b0);
            if (resp_sb.size() == 0) begin
                check("resp_unexpected_ifu", io_ifu_respValid, 1'b0);
                check("resp_unexpected_lsu", io_lsu_respValid, 1'b0);
            end else begin
                e = resp_sb.pop_front();
                check("resp_port", got_port, e.port);
                check("resp_cycle", cyc, e.cyc);
                check("resp_rdata", got_port == 1 ? io_lsu_rdata : io_ifu_rdata, e.rdata);
                check("resp_err", got_port == 1 ? io_lsu_err : io_ifu_err, e.err);
            end
        end
    end

    // Memory-request monitor.
    always @(negedge clock) begin
        if (!reset && io_mem_reqValid) begin
            mreq_t m;
            if (mreq_sb.size() == 0) begin
                check("mreq_unexpected", io_mem_reqValid, 1'b0);
            end else begin
                m = mreq_sb.pop_front();
                check("mreq_cycle", cyc, m.cyc);
                check("mreq_addr", io_mem_addr, m.addr);
                check("mreq_size", io_mem_size, m.size);
                check("mreq_wen", io_mem_wen, m.wen);
                check("mreq_wdata", io_mem_wdata, m.wdata);
                check("mreq_wmask", io_mem_wmask, m.wmask);
            end
        end
    end

    initial begin
        int t0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_memreq", io_mem_reqValid, 1'b0);
        check("rst_mem_addr", io_mem_addr, 32'h0);
        check("rst_ifu_resp", io_ifu_respValid, 1'b0);
        check("rst_lsu_resp", io_lsu_respValid, 1'b0);
        check("rst_ifu_rdata", io_ifu_rdata, 32'h0);
        reset = 1'b0;
        repeat (2) tick();

        // Single IFU fetch.
        t0 = cyc;
        io_ifu_reqValid = 1'b1;
        io_ifu_addr     = 32'h8000_0000;
        exp_ifu_req(32'h8000_0000, t0 + 1);
        exp_resp(0, 32'h0010_0093, 1'b0, t0 + 4);
        tick();
        io_ifu_reqValid = 1'b0;
        io_ifu_addr     = 32'h1234_5678;
        check("t1_grant", grant, 2'b01);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_addr_hold", io_mem_addr, 32'h8000_0000);
        wait_until(t0 + 3);
        mem_respond(32'h0010_0093);
        wait_until(t0 + 6);
        check("t1_idle", busy, 1'b0);

        // Simultaneous IFU + LSU: LSU first, IFU after one IDLE cycle.
        t0 = cyc;
        io_ifu_reqValid = 1'b1;
        io_ifu_addr     = 32'h8000_0004;
        io_lsu_reqValid = 1'b1;
        io_lsu_addr     = 32'h0000_0100;
        io_lsu_size     = 2'b00;
        io_lsu_wen      = 1'b1;
        io_lsu_wdata    = 32'h0000_00AB;
        io_lsu_wmask    = 4'b0001;
        mreq_sb.push_back('{addr: 32'h100, size: 2'b00, wen: 1'b1, wdata: 32'hAB, wmask: 4'b0001, cyc: t0 + 1});
        exp_resp(1, 32'h5555_0000, 1'b0, t0 + 3);
        exp_ifu_req(32'h8000_0004, t0 + 4);
        exp_resp(0, 32'hCAFE_F00D, 1'b0, t0 + 6);
        tick();
        io_ifu_reqValid = 1'b0;
        io_lsu_reqValid = 1'b0;
        io_lsu_wen      = 1'b0;
        check("t2_grant_lsu", grant, 2'b10);
        wait_until(t0 + 2);
        mem_respond(32'h5555_0000);
        check("t2_idle_gap", busy, 1'b0);
        wait_until(t0 + 5);
        mem_respond(32'hCAFE_F00D);
        wait_until(t0 + 8);

        // Timeout with a silent memory, then a stray late response.
        t0 = cyc;
        io_ifu_reqValid = 1'b1;
        io_ifu_addr     = 32'h8000_0100;
        exp_ifu_req(32'h8000_0100, t0 + 1);
        exp_resp(0, 32'hDEAD_BEEF, 1'b1, t0 + 6);
        tick();
        io_ifu_reqValid = 1'b0;
        wait_until(t0 + 6);
        check("t3_idle_after_to", busy, 1'b0);
        wait_until(t0 + 8);
        mem_respond(32'h0BAD_0BAD);
        wait_until(t0 + 11);

        // Memory answers on the 4th counted BUSY cycle: normal response wins.
        t0 = cyc;
        io_lsu_reqValid = 1'b1;
        io_lsu_addr     = 32'h0000_0200;
        io_lsu_size     = 2'b10;
        io_lsu_wen      = 1'b0;
        io_lsu_wdata    = 32'h0;
        io_lsu_wmask    = 4'b0000;
        mreq_sb.push_back('{addr: 32'h200, size: 2'b10, wen: 1'b0, wdata: 32'h0, wmask: 4'b0000, cyc: t0 + 1});
        exp_resp(1, 32'h7777_1111, 1'b0, t0 + 5);
        tick();
        io_lsu_reqValid = 1'b0;
        wait_until(t0 + 4);
        mem_respond(32'h7777_1111);
        wait_until(t0 + 8);

        // Reset in the middle of a transaction drops it without a response.
        t0 = cyc;
        io_ifu_reqValid = 1'b1;
        io_ifu_addr     = 32'h8000_0200;
        exp_ifu_req(32'h8000_0200, t0 + 1);
        tick();
        io_ifu_reqValid = 1'b0;
        wait_until(t0 + 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_grant", grant, 2'b00);
        wait_until(t0 + 4);
        mem_respond(32'h9999_9999);
        wait_until(t0 + 8);
        check("t5_busy_end", busy, 1'b0);

        // Second IFU pulse while the first is in flight is ignored.
        t0 = cyc;
        io_ifu_reqValid = 1'b1;
        io_ifu_addr     = 32'h8000_0300;
        exp_ifu_req(32'h8000_0300, t0 + 1);
        exp_resp(0, 32'h0000_0013, 1'b0, t0 + 4);
        tick();
        io_ifu_reqValid = 1'b0;
        tick();
        io_ifu_reqValid = 1'b1;
        io_ifu_addr     = 32'h8000_0400;
        tick();
        io_ifu_reqValid = 1'b0;
        mem_respond(32'h0000_0013);
        wait_until(t0 + 10);

        // LSU request arriving while IFU is BUSY is buffered and granted afterwards.
        t0 = cyc;
        io_ifu_reqValid = 1'b1;
        io_ifu_addr     = 32'h8000_0500;
        exp_ifu_req(32'h8000_0500, t0 + 1);
        exp_resp(0, 32'h1111_2222, 1'b0, t0 + 4);
        mreq_sb.push_back('{addr: 32'h300, size: 2'b01, wen: 1'b1, wdata: 32'hBEEF, wmask: 4'b0011, cyc: t0 + 5});
        exp_resp(1, 32'h3333_4444, 1'b0, t0 + 7);
        tick();
        io_ifu_reqValid = 1'b0;
        tick();
        io_lsu_reqValid = 1'b1;
        io_lsu_addr     = 32'h0000_0300;
        io_lsu_size     = 2'b01;
        io_lsu_wen      = 1'b1;
        io_lsu_wdata    = 32'h0000_BEEF;
        io_lsu_wmask    = 4'b0011;
        tick();
        io_lsu_reqValid = 1'b0;
        io_lsu_wen      = 1'b0;
        mem_respond(32'h1111_2222);
        wait_until(t0 + 6);
        mem_respond(32'h3333_4444);
        wait_until(t0 + 10);

        check("sb_resp_left", resp_sb.size(), 0);
        check("sb_mreq_left", mreq_sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
